operand_loader: RTL and testbench
=================================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter A_LEN, default 15: number of mat_a elements per frame.
REQ-002 Parameter B_LEN, default 16: number of mat_b elements per frame; N = A_LEN+B_LEN bytes per frame.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  8  signed operand byte.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_last  input  1  marks the final byte of a frame; sampled only on accept.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 mat_a  output  8 x A_LEN signed  element i = frame byte i.
REQ-010 mat_b  output  8 x B_LEN signed  element j = frame byte A_LEN+j.
REQ-011 out_valid  output  1  complete frame presented on mat_a/mat_b.
REQ-012 out_ready  input  1  consumer takes the presented frame.
REQ-013 frame_err  output  1  one-cycle pulse on a malformed frame.

Function
REQ-014 A byte SHALL be accepted exactly on cycles with in_valid=1 and in_ready=1; write pointer advances 0..N-1.
REQ-015 Accepted byte k SHALL be stored verbatim to mat_a[k] for k<A_LEN, else to mat_b[k-A_LEN]; no arithmetic or sign change.
REQ-016 States SHALL be FILL and HOLD; in FILL in_ready=1 and out_valid=0.
REQ-017 Accepting byte N-1 with in_last=1 SHALL move to HOLD; out_valid=1 on the cycle after that accept (latency 1 cycle).
REQ-018 In HOLD, in_ready SHALL be 0 and mat_a/mat_b SHALL be stable.
REQ-019 out_valid SHALL stay 1 until a cycle with out_valid=1 and out_ready=1; it SHALL never be retracted without that handshake.
REQ-020 On that handshake, the next cycle SHALL be FILL with pointer 0.
REQ-021 in_ready SHALL depend on registered state only, never combinationally on out_ready or in_valid.
REQ-022 Accepting in_last=1 at pointer < N-1, or in_last=0 at pointer N-1, SHALL pulse frame_err for exactly the next cycle, reset the pointer to 0, stay in FILL and never assert out_valid for that frame.
REQ-023 Register elements not yet written in the current frame SHALL retain prior values; outputs are defined only while out_valid=1.
REQ-024 in_valid=0 gaps of any length mid-frame SHALL not disturb the pointer or the stored bytes.

Reset
REQ-025 While rst=1, asynchronously: state FILL, pointer 0, out_valid 0, frame_err 0, all mat_a/mat_b elements 0.
REQ-026 in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-027 Reset mid-frame SHALL discard the partial frame; reset in HOLD SHALL drop the held frame with no handshake.

Configuration
REQ-028 Macro OPERAND_LOADER_DBUF_EN SHALL select double buffering.
REQ-029 When undefined, one register bank SHALL exist and REQ-016 to REQ-020 SHALL apply as written.
REQ-030 When defined, two banks SHALL ping-pong: filling SHALL continue into the free bank while the other is held; in_ready=0 only when both banks hold complete frames.
REQ-031 With DBUF, a handshake on bank X SHALL present the other bank on the next cycle with out_valid held 1 if that bank is complete; otherwise out_valid SHALL drop to 0.
REQ-032 With DBUF, completing bank Y on the same cycle as the handshake of bank X SHALL give out_valid=1 with bank Y on the next cycle.
REQ-033 Frames SHALL be presented in arrival order.

Verification
REQ-034 After reset, stream bytes 1..31 back-to-back with in_last on byte 31 -> one cycle later out_valid=1, mat_a[0]=1, mat_a[14]=15, mat_b[0]=16, mat_b[15]=31.
REQ-035 Hold out_ready=0 for 10 cycles, then 1 for one cycle -> out_valid stays 1 and outputs stay stable for all 10 cycles; in_ready=0 throughout (no DBUF); FILL entered after the handshake.
REQ-036 in_last=1 on byte 20 -> frame_err=1 for one cycle, out_valid stays 0; a following good frame of bytes -1..-31 is presented correctly.
REQ-037 Assert rst after byte 9 of a frame, then send a full frame -> outputs reset to 0 and the new frame is presented with no residue.
REQ-038 With OPERAND_LOADER_DBUF_EN: send two frames while out_ready=0 -> in_ready=0 after byte 62; on handshake, frame 2 is presented the next cycle with out_valid unbroken.

Source files
------------

// File: rtl/operand_loader_if.sv
// Operand loader bus: byte-stream input side and frame-presentation output side.
//
// Handshake semantics (both directions): a transfer happens on a rising clock
// edge where valid and ready are both 1. A producer holding valid=1 keeps its
// payload stable and never drops valid until that transfer. Ready may be
// asserted independently of valid.
//   input side : in_valid/in_ready carry one byte (in_data, in_last).
//   output side: out_valid/out_ready carry one whole frame (mat_a, mat_b).
// dbg_state mirrors the loader's state register for checkers (0 = filling,
// nothing held).
interface operand_loader_if #(
  parameter int A_LEN = 15,
  parameter int B_LEN = 16
);
  logic signed [7:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic signed [7:0] mat_a [A_LEN];
  logic signed [7:0] mat_b [B_LEN];
  logic              out_valid;
  logic              out_ready;
  logic              frame_err;
  logic [1:0]        dbg_state;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, mat_a, mat_b, out_valid, frame_err, dbg_state
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, mat_a, mat_b, out_valid, frame_err, dbg_state
  );
endinterface

// File: rtl/operand_loader.sv
// Operand loader: collects a frame of A_LEN+B_LEN signed bytes from a byte
// stream and presents it as two parallel operand vectors (mat_a, mat_b).
// Malformed frames (in_last early or missing) raise a one-cycle frame_err and
// are discarded.
//
// Build option: define OPERAND_LOADER_DBUF_EN for two ping-pong register
// banks, so a new frame can be filled while the previous one is held.
// Without it a single bank is used and input stalls while a frame is held.
module operand_loader #(
  parameter int A_LEN = 15,
  parameter int B_LEN = 16
) (
  input logic             clk,
  input logic             rst,
  operand_loader_if.slave bus
);
  localparam int N     = A_LEN + B_LEN;
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N - 1);

  logic [PTR_W-1:0] ptr_q;
  logic             frame_err_q;
  logic             fill_ok;     // registered-state-only in_ready
  logic             present_ok;  // registered-state-only out_valid
  logic             accept;
  logic             at_last;
  logic             frame_done;
  logic             frame_bad;
  logic             handshake;

  assign accept     = bus.in_valid & fill_ok;
  assign at_last    = (ptr_q == PTR_LAST);
  assign frame_done = accept & at_last & bus.in_last;
  assign frame_bad  = accept & (at_last ^ bus.in_last);
  assign handshake  = present_ok & bus.out_ready;

  assign bus.in_ready  = fill_ok;
  assign bus.out_valid = present_ok;
  assign bus.frame_err = frame_err_q;

  // Write pointer: restarts at 0 after any frame boundary, good or bad.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (at_last | bus.in_last) ? '0 : ptr_q + 1'b1;
    end
  end

  // Error pulse for exactly the cycle after a malformed boundary is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_bad;
    end
  end

`ifdef OPERAND_LOADER_DBUF_EN

  // FILL: no bank held. HOLD: one bank presented, other filling.
  // FULL: both banks hold complete frames, input stalled.
  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              wr_q;  // bank being filled
  logic              rd_q;  // bank being presented (oldest complete frame)
  logic signed [7:0] bank0_q [N];
  logic signed [7:0] bank1_q [N];

  assign fill_ok       = (state_q != FULL);
  assign present_ok    = (state_q != FILL);
  assign bus.dbg_state = state_q;

  // State register plus bank selectors; selectors flip on completion/handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (frame_done) wr_q <= ~wr_q;
      if (handshake)  rd_q <= ~rd_q;
    end
  end

  // Occupancy: a completed frame adds one held bank, a handshake frees one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (frame_done) state_d = HOLD;
      end
      HOLD: begin
        if (frame_done && !handshake)      state_d = FULL;
        else if (!frame_done && handshake) state_d = FILL;
      end
      FULL: begin
        if (handshake) state_d = HOLD;
      end
      default: state_d = FILL;
    endcase
  end

  // Accepted bytes land verbatim in the bank currently being filled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        bank0_q[k] <= '0;
        bank1_q[k] <= '0;
      end
    end else if (accept) begin
      if (wr_q) bank1_q[ptr_q] <= bus.in_data;
      else      bank0_q[ptr_q] <= bus.in_data;
    end
  end

  // Present the read bank split into its two operand vectors.
  always_comb begin
    for (int i = 0; i < A_LEN; i++) begin
      bus.mat_a[i] = rd_q ? bank1_q[i] : bank0_q[i];
    end
    for (int j = 0; j < B_LEN; j++) begin
      bus.mat_b[j] = rd_q ? bank1_q[A_LEN+j] : bank0_q[A_LEN+j];
    end
  end

`else

  // FILL: accepting bytes. HOLD: complete frame presented, input stalled.
  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1
  } state_t;

  state_t            state_q, state_d;
  logic signed [7:0] bank_q [N];

  assign fill_ok       = (state_q == FILL);
  assign present_ok    = (state_q == HOLD);
  assign bus.dbg_state = state_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Enter HOLD on a good frame; return to FILL once the consumer takes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (frame_done) state_d = HOLD;
      end
      HOLD: begin
        if (handshake) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Accepted bytes land verbatim at the write pointer; untouched slots keep
  // their previous contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        bank_q[k] <= '0;
      end
    end else if (accept) begin
      bank_q[ptr_q] <= bus.in_data;
    end
  end

  // Present the bank split into its two operand vectors.
  always_comb begin
    for (int i = 0; i < A_LEN; i++) begin
      bus.mat_a[i] = bank_q[i];
    end
    for (int j = 0; j < B_LEN; j++) begin
      bus.mat_b[j] = bank_q[A_LEN+j];
    end
  end

`endif

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: directed scenarios plus randomized frames, with a
// frame scoreboard fed by the driver and drained by an output monitor.
module tb_operand_loader;
  localparam int A_LEN = 15;
  localparam int B_LEN = 16;
  localparam int N     = A_LEN + B_LEN;
  localparam int FW    = N * 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand_loader_if #(.A_LEN(A_LEN), .B_LEN(B_LEN)) bus ();

  operand_loader #(.A_LEN(A_LEN), .B_LEN(B_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- bench state ----------------
  int n_cmp    = 0;
  int n_fail   = 0;
  int err_exp  = 0;
  int err_seen = 0;
  int gap_max  = 0;
  int ready_mode = 0;       // 0 manual, 1 always ready, 2 random
  logic ready_manual = 1'b0;
  logic ready_auto   = 1'b0;
  logic [FW-1:0] exp_q[$];  // complete frames in arrival order

  assign bus.out_ready = (ready_mode == 0) ? ready_manual : ready_auto;

  // out_ready generator for the automatic modes.
  initial begin
    forever begin
      @(posedge clk); #1;
      ready_auto = (ready_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  function automatic logic [FW-1:0] obs_frame();
    logic [FW-1:0] f;
    for (int i = 0; i < A_LEN; i++) f[i*8 +: 8] = bus.mat_a[i];
    for (int j = 0; j < B_LEN; j++) f[(A_LEN+j)*8 +: 8] = bus.mat_b[j];
    return f;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_frame(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rst = 1'b0;
  endtask

  // Optional idle gap, then offer one byte until accepted. Returns #1 after
  // the accepting edge.
  task automatic send_byte(input logic [7:0] d, input bit last);
    int waitc;
    repeat ($urandom_range(0, gap_max)) begin
      @(posedge clk); #1;
    end
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    waitc = 0;
    while (!bus.in_ready && waitc < 2000) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, expected 1", waitc);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Reference rule: a frame is good iff exactly N bytes arrive with in_last
  // on the N-th byte only; anything else is one frame error.
  task automatic send_frame(input logic [FW-1:0] f, input int len, input bit with_last);
    for (int k = 0; k < len; k++) begin
      send_byte(f[k*8 +: 8], with_last && (k == len - 1));
    end
    if (len == N && with_last) exp_q.push_back(f);
    else err_exp++;
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int k = 0; k < N; k++) f[k*8 +: 8] = 8'($urandom_range(0, 255));
    return f;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic prev_v;
    logic prev_r;
    prev_v = 1'b0;
    prev_r = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
        prev_r = 1'b0;
      end else begin
        if (bus.frame_err) err_seen++;
        if (prev_v && !prev_r) check("out_valid_held", int'(bus.out_valid), 1);
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_frame: got %h, expected no frame", obs_frame());
          end else begin
            check_frame("frame", obs_frame(), exp_q[0]);
            if (bus.out_ready) void'(exp_q.pop_front());
          end
`ifndef OPERAND_LOADER_DBUF_EN
          check("in_ready_in_hold", int'(bus.in_ready), 0);
`endif
        end
        prev_v = bus.out_valid;
        prev_r = bus.out_ready;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [FW-1:0] f;
    logic [FW-1:0] f2;
    int kind;
    int waitc;

    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    do_reset();

    // Reset state.
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_frame_err", int'(bus.frame_err), 0);
    check_frame("rst_mats", obs_frame(), '0);

    // Bytes 1..31 back-to-back, consumer not ready.
    ready_mode = 0;
    ready_manual = 1'b0;
    gap_max = 0;
    for (int k = 0; k < N; k++) f[k*8 +: 8] = 8'(k + 1);
    send_frame(f, N, 1'b1);
    check("latency_out_valid", int'(bus.out_valid), 1);
    check("mat_a0", int'(bus.mat_a[0]), 1);
    check("mat_a14", int'(bus.mat_a[14]), 15);
    check("mat_b0", int'(bus.mat_b[0]), 16);
    check("mat_b15", int'(bus.mat_b[15]), 31);

    // Hold for 10 cycles, then one-cycle handshake.
    for (int c = 0; c < 10; c++) begin
      check("hold_out_valid", int'(bus.out_valid), 1);
`ifndef OPERAND_LOADER_DBUF_EN
      check("hold_in_ready", int'(bus.in_ready), 0);
`endif
      @(posedge clk); #1;
    end
    ready_manual = 1'b1;
    @(posedge clk); #1;
    ready_manual = 1'b0;
    check("post_hs_state_fill", int'(bus.dbg_state), 0);
    check("post_hs_out_valid", int'(bus.out_valid), 0);
    check("post_hs_in_ready", int'(bus.in_ready), 1);

    // in_last on byte 20 -> error pulse, no frame.
    f = rand_frame();
    send_frame(f, 20, 1'b1);
    check("early_last_err", int'(bus.frame_err), 1);
    check("early_last_no_valid", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    check("early_last_err_pulse", int'(bus.frame_err), 0);

    // Good frame of bytes -1..-31.
    ready_mode = 1;
    for (int k = 0; k < N; k++) f[k*8 +: 8] = 8'(-(k + 1));
    send_frame(f, N, 1'b1);
    check("neg_out_valid", int'(bus.out_valid), 1);
    check("neg_mat_a0", int'(bus.mat_a[0]), -1);
    check("neg_mat_b15", int'(bus.mat_b[15]), -31);
    @(posedge clk); #1;

    // Reset mid-frame after 9 bytes, then a full frame.
    ready_mode = 0;
    ready_manual = 1'b0;
    for (int k = 0; k < 9; k++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    do_reset();
    check_frame("midframe_rst_mats", obs_frame(), '0);
    check("midframe_rst_out_valid", int'(bus.out_valid), 0);
    check("midframe_rst_in_ready", int'(bus.in_ready), 1);
    ready_mode = 1;
    f = rand_frame();
    send_frame(f, N, 1'b1);
    check("after_rst_out_valid", int'(bus.out_valid), 1);
    @(posedge clk); #1;

    // Missing in_last on byte N.
    f = rand_frame();
    send_frame(f, N, 1'b0);
    check("missing_last_err", int'(bus.frame_err), 1);
    check("missing_last_no_valid", int'(bus.out_valid), 0);
    @(posedge clk); #1;

`ifdef OPERAND_LOADER_DBUF_EN
    // Two frames while consumer stalls, then one handshake.
    ready_mode = 0;
    ready_manual = 1'b0;
    f  = rand_frame();
    f2 = rand_frame();
    send_frame(f, N, 1'b1);
    send_frame(f2, N, 1'b1);
    check("dbuf_both_full_in_ready", int'(bus.in_ready), 0);
    ready_manual = 1'b1;
    @(posedge clk); #1;
    ready_manual = 1'b0;
    check("dbuf_second_valid", int'(bus.out_valid), 1);
    check_frame("dbuf_second_frame", obs_frame(), f2);
    check("dbuf_in_ready_free", int'(bus.in_ready), 1);
    ready_mode = 1;
    @(posedge clk); #1;
`endif

    // Randomized frames with idle gaps and random consumer backpressure.
    gap_max = 2;
    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      f = rand_frame();
      kind = $urandom_range(0, 9);
      if (kind <= 6)      send_frame(f, N, 1'b1);
      else if (kind <= 8) send_frame(f, $urandom_range(1, N - 1), 1'b1);
      else                send_frame(f, N, 1'b0);
    end

    // Drain.
    ready_mode = 1;
    waitc = 0;
    while (exp_q.size() != 0 && waitc < 200) begin
      @(posedge clk); #1;
      waitc++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_remaining", exp_q.size(), 0);
    check("frame_err_count", err_seen, err_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
